// File: rtl/prbs_rx_par.sv
// Parallel PRBS checker: self-synchronising per-word prediction, HUNT/LOCK tracking and saturating
// locked bit/error counters with snapshot-and-clear. err_vec one cycle after the word; no backpressure.
`timescale 1ns/1ps
module prbs_rx_par #(
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_CNT_WIDTH = 32,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int LOCK_CNT      = 16,
  parameter int UNLOCK_CNT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_vld,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic [2:0]               prbs_sel,
  input  logic                     cnt_latch,
  output logic                     lock,
  output logic                     err_vld,
  output logic [DATA_WIDTH-1:0]    err_vec,
  output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     cnt_sat,
  output logic                     snap_vld
);
  localparam int GW  = $clog2(LOCK_CNT + 1);
  localparam int BW  = $clog2(UNLOCK_CNT + 1);
  localparam int PW  = $clog2(DATA_WIDTH + 1);
  localparam int BSW = BIT_CNT_WIDTH + PW;
  localparam int ESW = ERR_CNT_WIDTH + PW;
  localparam logic [BSW-1:0] BITS_MAX = {{PW{1'b0}}, {BIT_CNT_WIDTH{1'b1}}};
  localparam logic [ESW-1:0] ERRS_MAX = {{PW{1'b0}}, {ERR_CNT_WIDTH{1'b1}}};

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [30:0]              hist_q, hist_d;
  logic [2:0]               sel_q, sel_d;
  logic [GW-1:0]            good_q, good_d;
  logic [BW-1:0]            bad_q, bad_d;
  logic [BIT_CNT_WIDTH-1:0] run_bits_q, run_bits_d, bit_cnt_q, bit_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] run_errs_q, run_errs_d, err_cnt_q, err_cnt_d;
  logic                     run_sat_q, run_sat_d, cnt_sat_q, cnt_sat_d;
  logic                     err_vld_q, err_vld_d, snap_vld_q, snap_vld_d;
  logic [DATA_WIDTH-1:0]    err_vec_q, err_vec_d;

  logic [4:0]            tap_a, tap_b;
  logic [30:0]           ord_mask;
  logic                  sel_ok;
  logic [30:0]           hist_new;
  logic [DATA_WIDTH-1:0] mis;
  logic [PW-1:0]         mis_cnt;
  logic                  flush, act, chk_word, word_err, word_good, cnt_en;
  logic [BSW-1:0]        bits_sum;
  logic [ESW-1:0]        errs_sum;
  logic                  bits_ovf, errs_ovf;

  always_comb begin
    sel_ok   = 1'b1;
    tap_a    = 5'd7;
    tap_b    = 5'd6;
    ord_mask = 31'h0000_007F;
    case (sel_q)
      3'd0: ;
      3'd1: begin tap_a = 5'd9;  tap_b = 5'd5;  ord_mask = 31'h0000_01FF; end
      3'd2: begin tap_a = 5'd11; tap_b = 5'd9;  ord_mask = 31'h0000_07FF; end
      3'd3: begin tap_a = 5'd15; tap_b = 5'd14; ord_mask = 31'h0000_7FFF; end
      3'd4: begin tap_a = 5'd23; tap_b = 5'd18; ord_mask = 31'h007F_FFFF; end
      3'd5: begin tap_a = 5'd31; tap_b = 5'd28; ord_mask = 31'h7FFF_FFFF; end
      default: sel_ok = 1'b0;
    endcase
  end

  // Oldest bit first; hist bit k holds the bit received k+1 steps ago, so taps may hit this word.
  always_comb begin
    hist_new = hist_q;
    mis      = '0;
    mis_cnt  = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      mis[i]   = din[i] ^ hist_new[tap_a - 5'd1] ^ hist_new[tap_b - 5'd1];
      hist_new = {hist_new[29:0], din[i]};
    end
    for (int i = 0; i < DATA_WIDTH; i++) mis_cnt = mis_cnt + PW'(mis[i]);
  end

  assign flush     = (prbs_sel != sel_q);
  assign act       = din_vld && !flush;
  assign chk_word  = act && sel_ok;
  assign word_err  = |mis;
  assign word_good = !word_err && ((hist_new & ord_mask) != '0);
  assign cnt_en    = chk_word && (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    good_d  = good_q;
    bad_d   = bad_q;
    sel_d   = prbs_sel;
    if (flush) begin
      hist_d  = '0;
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
    end else if (act) begin
      hist_d = hist_new;
      if (!sel_ok) begin
        state_d = HUNT;
        good_d  = '0;
        bad_d   = '0;
      end else if (state_q == HUNT) begin
        if (!word_good) begin
          good_d = '0;
        end else if (good_q + 1'b1 == GW'(LOCK_CNT)) begin
          state_d = LOCKED;
          good_d  = '0;
        end else begin
          good_d = good_q + 1'b1;
        end
      end else begin
        if (!word_err) begin
          bad_d = '0;
        end else if (bad_q + 1'b1 == BW'(UNLOCK_CNT)) begin
          state_d = HUNT;
          good_d  = '0;
          bad_d   = '0;
        end else begin
          bad_d = bad_q + 1'b1;
        end
      end
    end
  end

  // A latch restarts the running window from this cycle's own contribution.
  always_comb begin
    bits_sum   = BSW'(cnt_latch ? '0 : run_bits_q) + (cnt_en ? BSW'(DATA_WIDTH) : '0);
    errs_sum   = ESW'(cnt_latch ? '0 : run_errs_q) + (cnt_en ? ESW'(mis_cnt) : '0);
    bits_ovf   = bits_sum > BITS_MAX;
    errs_ovf   = errs_sum > ERRS_MAX;
    run_bits_d = bits_ovf ? '1 : bits_sum[BIT_CNT_WIDTH-1:0];
    run_errs_d = errs_ovf ? '1 : errs_sum[ERR_CNT_WIDTH-1:0];
    run_sat_d  = (run_sat_q && !cnt_latch) || bits_ovf || errs_ovf;
    bit_cnt_d  = cnt_latch ? run_bits_q : bit_cnt_q;
    err_cnt_d  = cnt_latch ? run_errs_q : err_cnt_q;
    cnt_sat_d  = cnt_latch ? run_sat_q : cnt_sat_q;
    snap_vld_d = cnt_latch;
    err_vld_d  = act;
    err_vec_d  = chk_word ? mis : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      sel_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      run_bits_q <= '0;
      run_errs_q <= '0;
      run_sat_q  <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      cnt_sat_q  <= 1'b0;
      snap_vld_q <= 1'b0;
      err_vld_q  <= 1'b0;
      err_vec_q  <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      sel_q      <= sel_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      run_bits_q <= run_bits_d;
      run_errs_q <= run_errs_d;
      run_sat_q  <= run_sat_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      cnt_sat_q  <= cnt_sat_d;
      snap_vld_q <= snap_vld_d;
      err_vld_q  <= err_vld_d;
      err_vec_q  <= err_vec_d;
    end
  end

  assign lock     = (state_q == LOCKED);
  assign err_vld  = err_vld_q;
  assign err_vec  = err_vec_q;
  assign bit_cnt  = bit_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign cnt_sat  = cnt_sat_q;
  assign snap_vld = snap_vld_q;
endmodule

// File: tb/tb_prbs_rx_par.sv
// Bench for prbs_rx_par: bit-serial reference model plus scripted scenarios and a randomized tail,
// run against a 16-bit and a 4-bit error-counter instance sharing one stimulus.
`timescale 1ns/1ps
module tb_prbs_rx_par;
  localparam int DW = 8;
  localparam int LOCKN = 16;
  localparam int UNLK = 4;
  localparam longint BMAX = 64'h0000_0000_FFFF_FFFF;
  localparam longint EMAX = 65535;
  localparam longint EMAX4 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, din_vld, cnt_latch;
  logic [DW-1:0] din;
  logic [2:0] prbs_sel;
  logic lock, err_vld, cnt_sat, snap_vld;
  logic [DW-1:0] err_vec;
  logic [31:0] bit_cnt;
  logic [15:0] err_cnt;
  logic lock_4, err_vld_4, cnt_sat_4, snap_vld_4;
  logic [DW-1:0] err_vec_4;
  logic [31:0] bit_cnt_4;
  logic [3:0] err_cnt_4;

  prbs_rx_par #(.DATA_WIDTH(DW), .BIT_CNT_WIDTH(32), .ERR_CNT_WIDTH(16), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLK)) dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .prbs_sel(prbs_sel), .cnt_latch(cnt_latch),
    .lock(lock), .err_vld(err_vld), .err_vec(err_vec), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
    .cnt_sat(cnt_sat), .snap_vld(snap_vld));

  prbs_rx_par #(.DATA_WIDTH(DW), .BIT_CNT_WIDTH(32), .ERR_CNT_WIDTH(4), .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLK)) dut4 (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .prbs_sel(prbs_sel), .cnt_latch(cnt_latch),
    .lock(lock_4), .err_vld(err_vld_4), .err_vec(err_vec_4), .bit_cnt(bit_cnt_4), .err_cnt(err_cnt_4),
    .cnt_sat(cnt_sat_4), .snap_vld(snap_vld_4));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void taps(input int sel, output int a, output int b);
    case (sel)
      0: begin a = 7;  b = 6;  end
      1: begin a = 9;  b = 5;  end
      2: begin a = 11; b = 9;  end
      3: begin a = 15; b = 14; end
      4: begin a = 23; b = 18; end
      5: begin a = 31; b = 28; end
      default: begin a = 0; b = 0; end
    endcase
  endfunction

  // Reference model: history is a plain list of received bits, newest at the back.
  bit mh[$];
  int m_sel, m_good, m_bad;
  bit m_lock, m_bsat, m_esat, m_esat4, cmp_en;
  longint m_bits, m_errs, m_errs4;
  logic e_lock, e_vld, e_snap, e_sat, e_sat4;
  logic [DW-1:0] e_vec;
  longint e_bit, e_err, e_err4;

  function automatic void hist_clear();
    mh.delete();
    for (int i = 0; i < 31; i++) mh.push_back(1'b0);
  endfunction

  always @(posedge clk) begin : model_p
    int a, b, pc;
    bit flush, ones;
    logic [DW-1:0] vec;
    longint cb, ce;
    cmp_en = 1'b1;
    if (!rst) begin
      hist_clear();
      m_sel = 0; m_lock = 0; m_good = 0; m_bad = 0;
      m_bits = 0; m_errs = 0; m_errs4 = 0; m_bsat = 0; m_esat = 0; m_esat4 = 0;
      e_lock = 0; e_vld = 0; e_vec = '0; e_snap = 0; e_bit = 0; e_err = 0; e_err4 = 0; e_sat = 0; e_sat4 = 0;
    end else begin
      flush = (int'(prbs_sel) != m_sel);
      m_sel = int'(prbs_sel);
      e_vld = 0; e_vec = '0; e_snap = 0; cb = 0; ce = 0;
      if (flush) begin
        hist_clear();
        m_lock = 0; m_good = 0; m_bad = 0;
      end else if (din_vld) begin
        e_vld = 1;
        taps(m_sel, a, b);
        if (a == 0) begin
          for (int i = DW - 1; i >= 0; i--) begin mh.push_back(din[i]); void'(mh.pop_front()); end
          m_lock = 0; m_good = 0; m_bad = 0;
        end else begin
          vec = '0; pc = 0;
          for (int i = DW - 1; i >= 0; i--) begin
            vec[i] = din[i] ^ mh[mh.size() - a] ^ mh[mh.size() - b];
            pc += int'(vec[i]);
            mh.push_back(din[i]);
            void'(mh.pop_front());
          end
          ones = 0;
          for (int k = 1; k <= a; k++) if (mh[mh.size() - k]) ones = 1;
          e_vec = vec;
          if (m_lock) begin
            cb = DW; ce = pc;
            if (pc != 0) begin
              m_bad++;
              if (m_bad == UNLK) begin m_lock = 0; m_bad = 0; m_good = 0; end
            end else m_bad = 0;
          end else begin
            if (pc == 0 && ones) begin
              m_good++;
              if (m_good == LOCKN) begin m_lock = 1; m_good = 0; end
            end else m_good = 0;
          end
        end
      end
      if (cnt_latch) begin
        e_snap = 1; e_bit = m_bits; e_err = m_errs; e_err4 = m_errs4;
        e_sat = m_bsat | m_esat; e_sat4 = m_bsat | m_esat4;
        m_bits = 0; m_errs = 0; m_errs4 = 0; m_bsat = 0; m_esat = 0; m_esat4 = 0;
      end
      m_bits += cb;  if (m_bits > BMAX)   begin m_bits = BMAX;   m_bsat = 1;  end
      m_errs += ce;  if (m_errs > EMAX)   begin m_errs = EMAX;   m_esat = 1;  end
      m_errs4 += ce; if (m_errs4 > EMAX4) begin m_errs4 = EMAX4; m_esat4 = 1; end
      e_lock = m_lock;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("lock", 64'(lock), 64'(e_lock));
      chk("err_vld", 64'(err_vld), 64'(e_vld));
      chk("err_vec", 64'(err_vec), 64'(e_vec));
      chk("snap_vld", 64'(snap_vld), 64'(e_snap));
      chk("bit_cnt", 64'(bit_cnt), 64'(e_bit));
      chk("err_cnt", 64'(err_cnt), 64'(e_err));
      chk("cnt_sat", 64'(cnt_sat), 64'(e_sat));
      chk("lock_w4", 64'(lock_4), 64'(e_lock));
      chk("err_vec_w4", 64'(err_vec_4), 64'(e_vec));
      chk("bit_cnt_w4", 64'(bit_cnt_4), 64'(e_bit));
      chk("err_cnt_w4", 64'(err_cnt_4), 64'(e_err4));
      chk("cnt_sat_w4", 64'(cnt_sat_4), 64'(e_sat4));
    end
  end

  // Stimulus generator: an independent PRBS source per selected polynomial.
  bit g[$];

  function automatic void gen_seed();
    g.delete();
    for (int i = 0; i < 31; i++) g.push_back(1'($urandom_range(0, 1)));
    g[30] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] gen_word(input int sel);
    int a, b;
    logic [DW-1:0] w;
    bit nb;
    taps(sel, a, b);
    w = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      nb = g[g.size() - a] ^ g[g.size() - b];
      w[i] = nb;
      g.push_back(nb);
      void'(g.pop_front());
    end
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic latch);
    din_vld = 1'b1; din = w; cnt_latch = latch;
    cyc();
    din_vld = 1'b0; cnt_latch = 1'b0; din = DW'($urandom);
  endtask

  task automatic idle_latch();
    din_vld = 1'b0; cnt_latch = 1'b1;
    cyc();
    cnt_latch = 1'b0;
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) begin
      din_vld = 1'b0; din = DW'($urandom);
      repeat ($urandom_range(1, 3)) cyc();
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    int errsum, n, sel;
    bit zero_lock;
    rst = 1'b0; din_vld = 1'b0; din = '0; prbs_sel = 3'd0; cnt_latch = 1'b0;
    repeat (3) cyc();
    chk("rst_lock", 64'(lock), 64'd0);
    chk("rst_err_vld", 64'(err_vld), 64'd0);
    chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    chk("rst_snap_vld", 64'(snap_vld), 64'd0);
    rst = 1'b1;
    gen_seed();

    // PRBS7 clean: locks by the 18th word, then 100 locked words with idle gaps
    for (int k = 0; k < 18; k++) send(gen_word(0), 1'b0);
    chk("lock_by_18", 64'(lock), 64'd1);
    idle_latch();
    for (int k = 0; k < 100; k++) begin maybe_gap(); send(gen_word(0), 1'b0); end
    idle_latch();
    chk("bits_100w", 64'(bit_cnt), 64'd800);
    chk("errs_100w", 64'(err_cnt), 64'd0);
    chk("sat_100w", 64'(cnt_sat), 64'd0);
    chk("model_bits_100w", 64'(e_bit), 64'd800);

    // Single bit flip in word 50: the bit itself plus the x^6/x^7 echoes
    errsum = 0;
    for (int k = 1; k <= 60; k++) begin
      w = gen_word(0);
      if (k == 50) w = w ^ (DW'(1) << $urandom_range(0, DW - 1));
      send(w, 1'b0);
      if (k >= 50) errsum += $countones(err_vec);
    end
    chk("flip_vec_total", 64'(errsum), 64'd3);
    chk("flip_lock", 64'(lock), 64'd1);
    idle_latch();
    chk("flip_err_cnt", 64'(err_cnt), 64'd3);
    chk("flip_bit_cnt", 64'(bit_cnt), 64'd480);

    // PRBS15 lock, then 4 inverted words: bit 14 of the burst sees one inverted tap and matches
    prbs_sel = 3'd3; gen_seed();
    for (int k = 0; k < 22; k++) send(gen_word(3), 1'b0);
    chk("lock15", 64'(lock), 64'd1);
    idle_latch();
    for (int k = 1; k <= 4; k++) begin
      send(~gen_word(3), 1'b0);
      if (k == 1) chk("inv_vec_all", 64'(err_vec), 64'hFF);
      if (k == 3) chk("inv_lock3", 64'(lock), 64'd1);
      if (k == 4) chk("inv_lock4", 64'(lock), 64'd0);
    end
    idle_latch();
    chk("inv_err_cnt", 64'(err_cnt), 64'd31);
    chk("inv_bit_cnt", 64'(bit_cnt), 64'd32);

    // Error saturation on the 4-bit instance: 7 isolated flips of 3 mismatches each
    for (int k = 0; k < 25; k++) send(gen_word(3), 1'b0);
    chk("relock15", 64'(lock), 64'd1);
    idle_latch();
    for (int f = 0; f < 7; f++) begin
      send(gen_word(3) ^ (DW'(1) << $urandom_range(0, DW - 1)), 1'b0);
      for (int k = 0; k < 3; k++) send(gen_word(3), 1'b0);
    end
    idle_latch();
    chk("sat_err16", 64'(err_cnt), 64'd21);
    chk("sat_flag16", 64'(cnt_sat), 64'd0);
    chk("sat_err4", 64'(err_cnt_4), 64'd15);
    chk("sat_flag4", 64'(cnt_sat_4), 64'd1);
    for (int k = 0; k < 10; k++) send(gen_word(3), 1'b0);
    idle_latch();
    chk("unsat_err4", 64'(err_cnt_4), 64'd0);
    chk("unsat_flag4", 64'(cnt_sat_4), 64'd0);

    // Latch coincident with an errored locked word
    send(gen_word(3), 1'b0);
    send(gen_word(3), 1'b0);
    send(gen_word(3) ^ (DW'(1) << $urandom_range(0, DW - 1)), 1'b1);
    chk("coin_snap_err", 64'(err_cnt), 64'd0);
    chk("coin_snap_bits", 64'(bit_cnt), 64'd16);
    for (int k = 0; k < 5; k++) send(gen_word(3), 1'b0);
    idle_latch();
    chk("coin_next_err", 64'(err_cnt), 64'd3);
    chk("coin_next_bits", 64'(bit_cnt), 64'd48);

    // Switch to PRBS31 while locked: flush word ignored, history refill plus LOCK_CNT words to relock
    prbs_sel = 3'd5; gen_seed();
    send(gen_word(5), 1'b0);
    chk("sw_lock_fall", 64'(lock), 64'd0);
    chk("sw_flush_vld", 64'(err_vld), 64'd0);
    n = 0;
    while (!lock && n < 40) begin send(gen_word(5), 1'b0); n++; end
    chk("relock31_in_20", 64'(n <= 20 && lock), 64'd1);

    // All-zero stream never locks
    prbs_sel = 3'd0; zero_lock = 0;
    for (int k = 0; k < 1000; k++) begin send('0, 1'b0); if (lock) zero_lock = 1; end
    chk("zeros_no_lock", 64'(zero_lock), 64'd0);

    // Reserved polynomial: err_vld pulses, err_vec stays 0
    prbs_sel = 3'd6;
    send(DW'($urandom), 1'b0);
    send(DW'($urandom | 1), 1'b0);
    chk("rsv_vld", 64'(err_vld), 64'd1);
    chk("rsv_vec", 64'(err_vec), 64'd0);

    // Reset overrides a coincident latch
    rst = 1'b0; din_vld = 1'b1; cnt_latch = 1'b1;
    cyc();
    chk("rst_over_snap", 64'(snap_vld), 64'd0);
    chk("rst_over_bits", 64'(bit_cnt), 64'd0);
    rst = 1'b1; din_vld = 1'b0; cnt_latch = 1'b0;

    // Randomized tail: polynomial switches, gaps, injected errors, random latches
    sel = 0; prbs_sel = 3'd0; gen_seed();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        sel = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
        gen_seed();
      end
      prbs_sel = 3'(sel);
      din_vld = ($urandom_range(0, 3) != 0);
      w = (sel < 6) ? (din_vld ? gen_word(sel) : DW'($urandom)) : DW'($urandom);
      if ($urandom_range(0, 15) == 0) w = w ^ DW'($urandom);
      din = w;
      cnt_latch = ($urandom_range(0, 19) == 0);
      cyc();
    end
    din_vld = 1'b0; cnt_latch = 1'b0;
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
